irq_req_capture: RTL
====================

IRQ_REQ_CAPTURE -- requirements
Module: irq_req_capture

Interface
REQ-001 SHALL have parameter: EDGE_MODE, default 1, 1 = capture rising edges of req_i, 0 = capture levels.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req_i  input  8  raw request lines, bit 7 highest priority.
REQ-005 SHALL have port: mask_i  input  8  per-bit enable, 1 = request eligible for selection.
REQ-006 SHALL have port: out_valid  output  1  out_idx holds a granted request.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts out_idx when high with out_valid.
REQ-008 SHALL have port: out_idx  output  3  binary index of the selected request.
REQ-009 SHALL have port: pending_o  output  8  current pending register.
REQ-010 SHALL have port: ovf_o  output  8  sticky per-bit overflow flags.
REQ-011 SHALL have port: clr_ovf_i  input  1  clears all ovf_o bits.

Function
REQ-012 SHALL register req_i into req_q every cycle; set vector = req_i & ~req_q when EDGE_MODE=1, and req_i when EDGE_MODE=0.
REQ-013 SHALL define a handshake as out_valid & out_ready at a rising edge; clr vector = one-hot(out_idx) on a handshake, else 0.
REQ-014 SHALL update pending <= (pending & ~clr) | set; set wins over clr on the same bit.
REQ-015 SHALL compute the candidate as the highest-index set bit of (pending & ~clr & mask_i), pending being the pre-update value.
REQ-016 SHALL load the output register (out_valid, out_idx) from the candidate whenever out_valid=0 or a handshake occurs; otherwise it SHALL hold both values unchanged.
REQ-017 SHALL keep out_idx stable while out_valid=1 and out_ready=0, even if a higher-priority request arrives or mask_i deasserts the held bit.
REQ-018 SHALL give latency: req_i edge sampled at edge N sets pending at N; out_valid rises at edge N+1 if the output stage is free.
REQ-019 SHALL sustain one handshake per cycle when several masked-in bits are pending.
REQ-020 SHALL assert out_valid=0 with out_idx=0 when no candidate exists at load time.
REQ-021 SHALL keep a masked pending bit pending, never selecting it until it is unmasked.
REQ-022 SHALL, in level mode, re-set a bit whose req_i is still high in the handshake cycle, because set wins.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, clear pending, req_q, out_valid, out_idx and ovf_o to 0; pending_o shall read 0.
REQ-024 SHALL discard in-flight requests on reset mid-operation; out_valid shall be 0 at the first edge with rst_n=0.
REQ-025 SHALL, in edge mode, treat a req_i bit that is high on the first edge after reset release as a rising edge, because req_q is 0.

Configuration
REQ-026 SHALL, when macro IRQ_CAP_OVERFLOW_EN is defined, set ovf_o[i] when set[i]=1 and pending[i]=1 and clr[i]=0.
REQ-027 SHALL, when IRQ_CAP_OVERFLOW_EN is defined, clear all ovf_o bits on clr_ovf_i=1; a new overflow in the same cycle wins.
REQ-028 SHALL, without IRQ_CAP_OVERFLOW_EN, drive ovf_o to constant 0 and ignore clr_ovf_i; the port list is unchanged.

Structure
REQ-029 SHALL take constants NUM_REQ=8 and IDX_W=3 from shared package irq_cap_pkg.
REQ-030 SHALL implement the candidate selection as a purely combinational sub-module prio_enc8 (8-bit vector in; 3-bit index and any-valid flag out).

Verification
REQ-031 SHALL cover: reset, then req_i=8'h00 -> out_valid=0, pending_o=0, ovf_o=0.
REQ-032 SHALL cover: mask_i=FF, req_i 00->24 in one cycle, out_ready=1 -> out_idx=5 at N+1, then out_idx=2 at N+2, then out_valid=0.
REQ-033 SHALL cover: out_ready=0, out_idx=2 held, then req bit 7 rises -> out_idx stays 2 until the handshake, then becomes 7.
REQ-034 SHALL cover: mask_i=7F, req bit 7 pulses -> pending_o=80, out_valid=0; then mask_i=FF -> out_idx=7 one cycle later.
REQ-035 SHALL cover: with IRQ_CAP_OVERFLOW_EN, two edges on bit 3 with out_ready=0 -> ovf_o=08; then clr_ovf_i=1 -> ovf_o=00.
REQ-036 SHALL cover: rst_n=0 while out_valid=1 with pending_o=C1 -> the next edge gives out_valid=0 and pending_o=00.

Source files
------------

// File: rtl/irq_cap_pkg.sv
// Shared sizing and helpers for the interrupt request capture block.
package irq_cap_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   req_idx_t;

    function automatic req_vec_t onehot(input req_idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder: highest set bit wins.
module prio_enc8
    import irq_cap_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_vec,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Ascending scan so the highest set index is the last to assign.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_req_capture.sv
// Captures request edges/levels into a pending register and grants them by priority.
// Optional sticky per-bit overflow flags are built when IRQ_CAP_OVERFLOW_EN is defined.
module irq_req_capture
    import irq_cap_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [NUM_REQ-1:0] pending_o,
    output logic [NUM_REQ-1:0] ovf_o,
    input  logic               clr_ovf_i
);

    req_vec_t r_req_q;
    req_vec_t r_pending;
    logic     r_out_valid;
    req_idx_t r_out_idx;

    req_vec_t w_set;
    req_vec_t w_clr;
    logic     w_hs;
    req_vec_t w_cand_vec;
    req_idx_t w_cand_idx;
    logic     w_cand_any;

    always_comb begin
        w_set = (EDGE_MODE != 0) ? (req_i & ~r_req_q) : req_i;
        w_hs  = r_out_valid & out_ready;
        w_clr = w_hs ? onehot(r_out_idx) : '0;
        // The bit being granted this cycle must not be re-selected from the old pending value.
        w_cand_vec = r_pending & ~w_clr & mask_i;
    end

    prio_enc8 u_prio (
        .i_vec (w_cand_vec),
        .o_idx (w_cand_idx),
        .o_any (w_cand_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_q     <= '0;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_req_q   <= req_i;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (!r_out_valid || w_hs) begin
                r_out_valid <= w_cand_any;
                r_out_idx   <= w_cand_any ? w_cand_idx : '0;
            end
        end
    end

`ifdef IRQ_CAP_OVERFLOW_EN
    req_vec_t r_ovf;

    // A fresh overflow in the clear cycle survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (clr_ovf_i ? req_vec_t'(0) : r_ovf) | (w_set & r_pending & ~w_clr);
        end
    end

    assign ovf_o = r_ovf;
`else
    logic w_unused_clr_ovf;
    assign w_unused_clr_ovf = clr_ovf_i;
    assign ovf_o            = '0;
`endif

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign pending_o = r_pending;

endmodule
